// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl
//   M-stage data-memory sequencer. Takes one load/store per instruction,
//   drives a word-wide req/ready memory, generates byte enables and
//   lane-replicated store data, stalls the pipeline while the access is in
//   flight and returns extended load data plus exception flags.
// Ports
//   clk, reset            : clock (rising edge), async active-high reset
//   req_*                 : M-stage request (valid/we/size/signed/addr/wdata)
//   stall                 : combinational pipeline freeze
//   rsp_valid/rsp_rdata   : one-cycle completion pulse and load data
//   exc_adel/ades/bus     : misaligned load / misaligned store / bus timeout
//   mem_*                 : memory port (req held until mem_ready)
module dm_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        exc_bus,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [1:0]      l_size;
  logic            l_signed;
  logic [1:0]      l_off;
  logic [CW-1:0]   cnt;

  logic            misal;
  logic [3:0]      be_c;
  logic [31:0]     wdata_c;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic [31:0]     ext_c;
  logic            timeout_hit;

  // Request decode from the live M-stage inputs (used only in IDLE).
  always_comb begin
    misal   = (req_size == 2'b11) ||
              (req_size == 2'b01 && req_addr[0]) ||
              (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    be_c    = 4'b1111;
    wdata_c = req_wdata;
    case (req_size)
      2'b00: begin
        be_c    = 4'b0001 << req_addr[1:0];
        wdata_c = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_c    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane select and extension using the latched request.
  always_comb begin
    lane_b = mem_rdata[{l_off, 3'b000} +: 8];
    lane_h = mem_rdata[{l_off[1], 4'b0000} +: 16];
    case (l_size)
      2'b00:   ext_c = {{24{l_signed & lane_b[7]}}, lane_b};
      2'b01:   ext_c = {{16{l_signed & lane_h[15]}}, lane_h};
      default: ext_c = mem_rdata;
    endcase
  end

  // cnt holds the number of BUSY cycles already completed, so the TIMEOUT-th
  // BUSY cycle is the one where cnt == TIMEOUT-1.
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  // State decode keeps mem_req/stall falling with the async reset itself.
  assign mem_req = (state == BUSY);
  assign stall   = (state == BUSY) || (state == IDLE && req_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      l_size    <= 2'b00;
      l_signed  <= 1'b0;
      l_off     <= 2'b00;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      exc_adel  <= 1'b0;
      exc_ades  <= 1'b0;
      exc_bus   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            l_size   <= req_size;
            l_signed <= req_signed;
            l_off    <= req_addr[1:0];
            if (misal) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              exc_adel  <= ~req_we;
              exc_ades  <= req_we;
            end else begin
              state     <= BUSY;
              cnt       <= '0;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= be_c;
              mem_wdata <= wdata_c;
            end
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (mem_ready) begin
            // ready beats the timeout on the same cycle
            state     <= DONE;
            rsp_valid <= 1'b1;
            rsp_rdata <= mem_we ? 32'h0 : ext_c;
          end else if (timeout_hit) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            exc_bus   <= 1'b1;
          end
        end
        DONE: begin
          // req_valid here is still the completing instruction: ignore it.
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          exc_adel  <= 1'b0;
          exc_ades  <= 1'b0;
          exc_bus   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: each transaction is turned into a cycle timeline
// (request cycle, N busy cycles, completion cycle, one idle cycle) from the
// access rules, and a single negedge process compares every output against it.
module tb_dm_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid, exc_adel, exc_ades, exc_bus;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  dm_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_bus(exc_bus),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  // expectations for the current cycle
  logic        chk_en = 1'b0;
  logic        e_stall, e_req, e_we, e_rsp, e_adel, e_ades, e_bus;
  logic [31:0] e_addr, e_wd, e_rdata;
  logic [3:0]  e_be;
  logic        e_lit;
  logic [31:0] lit_rd, lit_wd;
  logic [3:0]  lit_be;

  int vecs = 0;
  int miss = 0;

  function automatic logic model_misal(input logic [1:0] sz, input logic [31:0] ad);
    return (sz == 2'd3) || (sz == 2'd1 && ad % 2 != 0) || (sz == 2'd2 && ad % 4 != 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] ad);
    if (sz == 2'd0) return 4'(1 << (ad % 4));
    if (sz == 2'd1) return (ad % 4 >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] model_ext(input logic [1:0] sz, input logic sg,
                                            input logic [31:0] ad, input logic [31:0] rd);
    logic [31:0] v;
    if (sz == 2'd2) return rd;
    if (sz == 2'd0) begin
      v = (rd >> (8 * (ad % 4))) & 32'hFF;
      if (sg && v >= 32'd128) v = v - 32'd256;
    end else begin
      v = (rd >> (16 * ((ad % 4) / 2))) & 32'hFFFF;
      if (sg && v >= 32'd32768) v = v - 32'h1_0000;
    end
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s @%0t: got %h expected %h", n, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall",     32'(stall),     32'(e_stall));
      chk("mem_req",   32'(mem_req),   32'(e_req));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
      chk("rsp_rdata", rsp_rdata,      e_rdata);
      chk("exc_adel",  32'(exc_adel),  32'(e_adel));
      chk("exc_ades",  32'(exc_ades),  32'(e_ades));
      chk("exc_bus",   32'(exc_bus),   32'(e_bus));
      if (e_req) begin
        chk("mem_we",    32'(mem_we), 32'(e_we));
        chk("mem_addr",  mem_addr,    e_addr);
        chk("mem_be",    32'(mem_be), 32'(e_be));
        chk("mem_wdata", mem_wdata,   e_wd);
        if (e_lit) begin
          chk("lit_be",    32'(mem_be), 32'(lit_be));
          chk("lit_wdata", mem_wdata,   lit_wd);
        end
      end
      if (e_lit && e_rsp) chk("lit_rdata", rsp_rdata, lit_rd);
    end
  end

  task automatic idle_exp();
    e_stall = 0; e_req = 0; e_rsp = 0; e_rdata = 0;
    e_adel = 0; e_ades = 0; e_bus = 0; e_lit = 0;
  endtask

  // rdy_at: BUSY cycle (1-based) on which mem_ready is raised; 0 = never.
  task automatic run_txn(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] ad, input logic [31:0] wd,
                         input int rdy_at, input logic [31:0] rd,
                         input logic lit_en, input logic [31:0] l_rd,
                         input logic [3:0] l_be, input logic [31:0] l_wd);
    logic mis, bus;
    int   b, d;
    mis = model_misal(sz, ad);
    bus = !mis && (rdy_at <= 0 || rdy_at > TO);
    b   = mis ? 0 : (bus ? TO : rdy_at);
    d   = b + 1;
    req_we = we; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
    mem_rdata = rd;
    e_lit = lit_en; lit_rd = l_rd; lit_be = l_be; lit_wd = l_wd;
    for (int t = 0; t <= d + 1; t++) begin
      // the instruction stays on req_valid until the pipeline advances past DONE
      req_valid = (t <= d);
      mem_ready = !mis && t >= 1 && t == rdy_at;
      e_stall = (t == 0) || (t >= 1 && t <= b);
      e_req   = (t >= 1 && t <= b);
      e_we    = we;
      e_addr  = ad & ~32'h3;
      e_be    = model_be(sz, ad);
      e_wd    = model_wd(sz, wd);
      e_rsp   = (t == d);
      e_rdata = (t == d && !mis && !bus && !we) ? model_ext(sz, sg, ad, rd) : 32'h0;
      e_adel  = (t == d) && mis && !we;
      e_ades  = (t == d) && mis && we;
      e_bus   = (t == d) && bus;
      @(posedge clk); #1;
    end
    mem_ready = 0;
    e_lit = 0;
  endtask

  initial begin
    reset = 1; req_valid = 0; req_we = 0; req_size = 0; req_signed = 0;
    req_addr = 0; req_wdata = 0; mem_ready = 0; mem_rdata = 0;
    idle_exp(); e_we = 0; e_addr = 0; e_be = 0; e_wd = 0;
    lit_rd = 0; lit_be = 0; lit_wd = 0;
    #1 chk_en = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(posedge clk); #1;

    // lw, ready on first BUSY cycle
    run_txn(0, 2'd2, 0, 32'h100, 0, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 4'hF, 32'h0);
    // lb / lbu / lh sign extension
    run_txn(0, 2'd0, 1, 32'h103, 0, 1, 32'h80FF_0000, 1, 32'hFFFFFF80, 4'b1000, 32'h0);
    run_txn(0, 2'd0, 0, 32'h103, 0, 2, 32'h80FF_0000, 1, 32'h00000080, 4'b1000, 32'h0);
    run_txn(0, 2'd1, 1, 32'h102, 0, 1, 32'h80FF_0000, 1, 32'hFFFF80FF, 4'b1100, 32'h0);
    // sb, ready on 4th BUSY cycle
    run_txn(1, 2'd0, 0, 32'h201, 32'h0000_00AB, 4, 0, 1, 32'h0, 4'b0010, 32'hABABABAB);
    // assorted aligned accesses
    run_txn(0, 2'd1, 0, 32'h100, 0, 3, 32'h1234_F678, 1, 32'h0000F678, 4'b0011, 32'h0);
    run_txn(0, 2'd0, 1, 32'h101, 0, 2, 32'h0000_7F00, 1, 32'h0000007F, 4'b0010, 32'h0);
    run_txn(1, 2'd2, 0, 32'h300, 32'hCAFE_F00D, 3, 0, 1, 32'h0, 4'hF, 32'hCAFEF00D);
    run_txn(1, 2'd1, 0, 32'h302, 32'h5555_BEEF, 1, 0, 1, 32'h0, 4'b1100, 32'hBEEFBEEF);
    // misaligned
    run_txn(0, 2'd2, 0, 32'h102, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0);
    run_txn(1, 2'd1, 0, 32'h301, 32'h1234, 1, 0, 0, 0, 0, 0);
    run_txn(0, 2'd3, 0, 32'h100, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0);
    run_txn(1, 2'd3, 0, 32'h104, 32'h1, 1, 0, 0, 0, 0, 0);
    // timeout, then ready exactly on the timeout cycle
    run_txn(0, 2'd2, 0, 32'h400, 0, 0, 32'h1111_2222, 0, 0, 0, 0);
    run_txn(0, 2'd2, 0, 32'h400, 0, TO, 32'h1111_2222, 1, 32'h11112222, 4'hF, 32'h0);

    // reset in the 2nd BUSY cycle aborts the access with no response
    req_we = 0; req_size = 2'd2; req_signed = 0; req_addr = 32'h500; mem_rdata = 32'h0;
    req_valid = 1; idle_exp(); e_stall = 1;
    e_we = 0; e_addr = 32'h500; e_be = 4'hF; e_wd = 32'h0;
    @(posedge clk); #1;
    e_req = 1;
    @(posedge clk); #1;
    reset = 1; req_valid = 0; idle_exp();
    repeat (2) begin @(posedge clk); #1; end
    reset = 0;
    repeat (2) begin @(posedge clk); #1; end
    run_txn(0, 2'd2, 0, 32'h500, 0, 2, 32'hA5A5_5A5A, 1, 32'hA5A55A5A, 4'hF, 32'h0);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
